// File: rtl/sobel_3x3.sv
// Streaming 3x3 Sobel edge detector: column window, Gx/Gy stage, |Gx|+|Gy| stage.
// Optional binarized output when SOBEL_THRESHOLD_EN is defined (default build: saturated magnitude).
module sobel_3x3 #(
  parameter int COLORDEPTH  = 8,
  parameter int SCREENWIDTH = 1600,
  parameter int THRESHOLD   = 128
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [2:0][COLORDEPTH-1:0] col_i,
  input  logic                       dv_i,
  input  logic                       line_end,
  output logic [COLORDEPTH-1:0]      edge_o,
  output logic                       dv_o
);

  localparam int GW = COLORDEPTH + 3;
  localparam logic [10:0] SAT_CNT = 11'(SCREENWIDTH);

  // The column counter is 11 bits wide, so the line length must fit in it.
  if (SCREENWIDTH > 2047 || SCREENWIDTH < 2 || THRESHOLD < 0) begin : g_bad_param
    $error("sobel_3x3: SCREENWIDTH must be 2..2047 and THRESHOLD non-negative");
  end

  logic [2:0][2:0][COLORDEPTH-1:0] win_q, win_d;
  logic [10:0]                     cnt_q, cnt_d;
  logic                            v1_q, v1_d;
  logic                            z1_q, z1_d;

  logic signed [GW-1:0]            gx_q, gx_d;
  logic signed [GW-1:0]            gy_q, gy_d;
  logic                            v2_q;
  logic                            z2_q;

  logic [COLORDEPTH-1:0]           edge_q, edge_d;
  logic                            dv_q;

  logic [GW-1:0]                   gx_abs, gy_abs, mag;
  logic [COLORDEPTH-1:0]           res;

  function automatic logic signed [GW-1:0] wide1(input logic [COLORDEPTH-1:0] p);
    return $signed({3'b000, p});
  endfunction

  function automatic logic signed [GW-1:0] wide2(input logic [COLORDEPTH-1:0] p);
    return $signed({2'b00, p, 1'b0});
  endfunction

  // S1: window shift/load. line_end clears state and drops a coincident pixel.
  always_comb begin
    win_d = win_q;
    cnt_d = cnt_q;
    v1_d  = 1'b0;
    z1_d  = z1_q;
    if (line_end) begin
      win_d = '0;
      cnt_d = '0;
    end else if (dv_i) begin
      for (int r = 0; r < 3; r++) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = win_q[r][2];
      end
      win_d[0][2] = col_i[2];
      win_d[1][2] = col_i[1];
      win_d[2][2] = col_i[0];
      if (cnt_q != SAT_CNT) begin
        cnt_d = cnt_q + 11'd1;
      end
      v1_d = 1'b1;
      z1_d = (cnt_q < 11'd2);
    end
  end

  always_comb begin
    gx_d = wide1(win_q[0][2]) + wide2(win_q[1][2]) + wide1(win_q[2][2])
         - wide1(win_q[0][0]) - wide2(win_q[1][0]) - wide1(win_q[2][0]);
    gy_d = wide1(win_q[2][0]) + wide2(win_q[2][1]) + wide1(win_q[2][2])
         - wide1(win_q[0][0]) - wide2(win_q[0][1]) - wide1(win_q[0][2]);
  end

  // S3: magnitude, then either saturation or thresholding.
  always_comb begin
    gx_abs = gx_q[GW-1] ? GW'(-gx_q) : GW'(gx_q);
    gy_abs = gy_q[GW-1] ? GW'(-gy_q) : GW'(gy_q);
    mag    = gx_abs + gy_abs;
`ifdef SOBEL_THRESHOLD_EN
    res = (mag >= GW'(THRESHOLD)) ? '1 : '0;
`else
    res = (|mag[GW-1:COLORDEPTH]) ? '1 : mag[COLORDEPTH-1:0];
`endif
    edge_d = edge_q;
    if (v2_q) begin
      edge_d = z2_q ? '0 : res;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_q  <= '0;
      cnt_q  <= '0;
      v1_q   <= 1'b0;
      z1_q   <= 1'b0;
      gx_q   <= '0;
      gy_q   <= '0;
      v2_q   <= 1'b0;
      z2_q   <= 1'b0;
      edge_q <= '0;
      dv_q   <= 1'b0;
    end else begin
      win_q <= win_d;
      cnt_q <= cnt_d;
      v1_q  <= v1_d;
      z1_q  <= z1_d;
      // Stage 2 is not touched by line_end, so results already in flight complete.
      if (v1_q) begin
        gx_q <= gx_d;
        gy_q <= gy_d;
        z2_q <= z1_q;
      end
      v2_q   <= v1_q;
      edge_q <= edge_d;
      dv_q   <= v2_q;
    end
  end

  assign edge_o = edge_q;
  assign dv_o   = dv_q;

endmodule
